gpio_pad_ctrl: RTL and testbench

Parametrised GPIO pad-side controller between the SoC GPIO core signals and the bidirectional pad cells (I/OEN/C pins). It registers the output and output-enable drive toward the pads and passes pad inputs through a multi-stage synchroniser and a per-channel runtime-programmable debouncer. It also detects debounced edges per channel (rise/fall/both) into sticky, maskable, write-1-to-clear interrupt-pending bits. It generalises the fixed 24-pin GPIO pad hookup to N channels and adds input conditioning and interrupts.

---
 rtl/gpio_pad_ctrl.sv | 85 ++++++++
 tb/tb_gpio_pad_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad-side controller: registered output/OE drive toward the pad cells, plus
// synchronised, debounced pad inputs with per-channel edge-detect interrupts.
module gpio_pad_ctrl #(
  parameter int N_GPIO      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_GPIO-1:0]     pad_c_i,
  output logic [N_GPIO-1:0]     pad_i_o,
  output logic [N_GPIO-1:0]     pad_oen_o,
  input  logic [N_GPIO-1:0]     gpio_out_i,
  input  logic [N_GPIO-1:0]     gpio_oe_i,
  output logic [N_GPIO-1:0]     gpio_in_o,
  input  logic [DB_WIDTH-1:0]   db_limit_i,
  input  logic [2*N_GPIO-1:0]   edge_mode_i,
  input  logic [N_GPIO-1:0]     irq_mask_i,
  input  logic [N_GPIO-1:0]     irq_clr_i,
  output logic [N_GPIO-1:0]     irq_pending_o,
  output logic                  irq_o
);

  logic [N_GPIO-1:0]   padI_q, padOen_q;
  logic [N_GPIO-1:0]   syncChain_q [SYNC_STAGES];
  logic [N_GPIO-1:0]   gpioIn_q, gpioIn_d;
  logic [DB_WIDTH-1:0] dbCnt_q [N_GPIO];
  logic [DB_WIDTH-1:0] dbCnt_d [N_GPIO];
  logic [N_GPIO-1:0]   pending_q, pending_d;
  logic [N_GPIO-1:0]   syncOut;
  logic [N_GPIO-1:0]   update;
  logic [DB_WIDTH-1:0] limitM1;

  // A limit of 0 behaves as 1, so the terminal count is never below zero.
  assign limitM1 = (db_limit_i == '0) ? '0 : db_limit_i - DB_WIDTH'(1);
  assign syncOut = syncChain_q[SYNC_STAGES-1];

  always_comb begin
    gpioIn_d  = gpioIn_q;
    update    = '0;
    pending_d = pending_q & ~irq_clr_i;
    for (int i = 0; i < N_GPIO; i++) begin
      dbCnt_d[i] = '0;
      // ">=" rather than "==" lets a freshly lowered limit take effect at once.
      if (syncOut[i] != gpioIn_q[i]) begin
        if (dbCnt_q[i] >= limitM1) begin
          update[i]   = 1'b1;
          gpioIn_d[i] = syncOut[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + DB_WIDTH'(1);
        end
      end
      if (update[i] && ((syncOut[i] && edge_mode_i[2*i]) ||
                        (!syncOut[i] && edge_mode_i[2*i+1]))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      padI_q    <= '0;
      padOen_q  <= '1;
      gpioIn_q  <= '0;
      pending_q <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) syncChain_q[k] <= '0;
      for (int i = 0; i < N_GPIO; i++) dbCnt_q[i] <= '0;
    end else begin
      padI_q    <= gpio_out_i;
      padOen_q  <= ~gpio_oe_i;
      gpioIn_q  <= gpioIn_d;
      pending_q <= pending_d;
      syncChain_q[0] <= pad_c_i;
      for (int k = 1; k < SYNC_STAGES; k++) syncChain_q[k] <= syncChain_q[k-1];
      for (int i = 0; i < N_GPIO; i++) dbCnt_q[i] <= dbCnt_d[i];
    end
  end

  assign pad_i_o       = padI_q;
  assign pad_oen_o     = padOen_q;
  assign gpio_in_o     = gpioIn_q;
  assign irq_pending_o = pending_q;
  assign irq_o         = |(pending_q & irq_mask_i);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: reset, output path, debounce latency and
// glitch rejection, edge modes, W1C race, masking and limit extremes.
module tb_gpio_pad_ctrl;
  localparam int N = 24;
  localparam int DBW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   padC, padI, padOen, gpioOut, gpioOe, gpioIn, irqMask, irqClr, irqPending;
  logic [DBW-1:0] dbLimit;
  logic [2*N-1:0] edgeMode;
  logic           irq;
  int             nChecks = 0;
  int             nFails  = 0;

  gpio_pad_ctrl #(.N_GPIO(N), .SYNC_STAGES(2), .DB_WIDTH(DBW)) dut (
    .clk(clk), .reset(reset), .pad_c_i(padC), .pad_i_o(padI), .pad_oen_o(padOen),
    .gpio_out_i(gpioOut), .gpio_oe_i(gpioOe), .gpio_in_o(gpioIn),
    .db_limit_i(dbLimit), .edge_mode_i(edgeMode), .irq_mask_i(irqMask),
    .irq_clr_i(irqClr), .irq_pending_o(irqPending), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Advance a number of clock edges, leaving time 1 unit past the last edge.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset    = 1'b1;
    padC     = '1;
    gpioOe   = '1;
    gpioOut  = '0;
    dbLimit  = 8'd4;
    edgeMode = '0;
    irqMask  = '0;
    irqClr   = '0;

    applyStimulus(1);
    checkOutput("rst_oen_1", 32'(padOen), 32'hFFFFFF);
    applyStimulus(1);
    checkOutput("rst_oen_2", 32'(padOen), 32'hFFFFFF);
    checkOutput("rst_padI", 32'(padI), 32'h0);
    checkOutput("rst_gpioIn", 32'(gpioIn), 32'h0);
    checkOutput("rst_pending", 32'(irqPending), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);

    // Release reset with pads still high: input restarts from 0, rises after 2+4.
    reset   = 1'b0;
    gpioOut = 24'hA5A5A5;
    applyStimulus(1);
    checkOutput("oen_after_rst", 32'(padOen), 32'h000000);
    checkOutput("padI_drive", 32'(padI), 32'hA5A5A5);
    applyStimulus(4);
    checkOutput("post_rst_in_5", 32'(gpioIn), 32'h0);
    applyStimulus(1);
    checkOutput("post_rst_in_6", 32'(gpioIn), 32'hFFFFFF);
    checkOutput("post_rst_nopend", 32'(irqPending), 32'h0);

    gpioOe = 24'h00F00F;
    padC   = '0;
    applyStimulus(8);
    checkOutput("oen_mixed", 32'(padOen), 32'hFF0FF0);
    checkOutput("pads_low", 32'(gpioIn), 32'h0);

    // Channel 3 latency with L=4.
    padC = 24'h000008;
    applyStimulus(5);
    checkOutput("ch3_lat_5", 32'(gpioIn[3]), 32'h0);
    applyStimulus(1);
    checkOutput("ch3_lat_6", 32'(gpioIn[3]), 32'h1);
    padC = '0;
    applyStimulus(8);

    // 3-cycle glitch on channel 5 is rejected.
    padC = 24'h000020;
    applyStimulus(3);
    padC = '0;
    applyStimulus(10);
    checkOutput("ch5_glitch", 32'(gpioIn), 32'h0);
    checkOutput("ch5_nopend", 32'(irqPending), 32'h0);

    // Edge modes: ch0 rise, ch1 fall, ch2 both, ch4 off.
    dbLimit  = 8'd1;
    edgeMode = 48'h39;
    padC     = 24'h000017;
    applyStimulus(10);
    checkOutput("modes_in_high", 32'(gpioIn), 32'h17);
    checkOutput("modes_pend_rise", 32'(irqPending), 32'h05);
    padC = '0;
    applyStimulus(10);
    checkOutput("modes_in_low", 32'(gpioIn), 32'h0);
    checkOutput("modes_pend_fall", 32'(irqPending), 32'h07);
    irqClr = 24'h000007;
    applyStimulus(1);
    irqClr = '0;
    checkOutput("modes_cleared", 32'(irqPending), 32'h0);

    // Channel 7 both-edges: clear strobe coincident with update loses to the set.
    edgeMode = 48'hC000;
    padC     = 24'h000080;
    applyStimulus(2);
    checkOutput("race_before", 32'(irqPending), 32'h0);
    irqClr = 24'h000080;
    applyStimulus(1);
    irqClr = '0;
    checkOutput("race_set_wins", 32'(irqPending), 32'h80);
    applyStimulus(1);
    checkOutput("race_sticky", 32'(irqPending), 32'h80);
    irqClr = 24'h000080;
    applyStimulus(1);
    irqClr = '0;
    checkOutput("race_later_clr", 32'(irqPending), 32'h0);

    // Channel 9 rise with masking.
    edgeMode = 48'h4C000;
    padC     = 24'h000280;
    applyStimulus(4);
    checkOutput("mask_pend9", 32'(irqPending), 32'h200);
    checkOutput("mask_off", 32'(irq), 32'h0);
    irqMask = 24'h000200;
    #1;
    checkOutput("mask_on", 32'(irq), 32'h1);
    irqMask = 24'h000100;
    #1;
    checkOutput("mask_other", 32'(irq), 32'h0);
    irqMask = 24'h000200;

    // Reset with pending set clears everything.
    reset = 1'b1;
    padC  = '0;
    edgeMode = '0;
    applyStimulus(1);
    checkOutput("rst2_pending", 32'(irqPending), 32'h0);
    checkOutput("rst2_gpioIn", 32'(gpioIn), 32'h0);
    checkOutput("rst2_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    applyStimulus(8);

    // L=0 acts as L=1.
    dbLimit = 8'd0;
    padC    = 24'h000400;
    applyStimulus(2);
    checkOutput("l0_lat_2", 32'(gpioIn[10]), 32'h0);
    applyStimulus(1);
    checkOutput("l0_lat_3", 32'(gpioIn[10]), 32'h1);

    // L=255: latency 257.
    dbLimit = 8'd255;
    padC    = 24'h000C00;
    applyStimulus(256);
    checkOutput("l255_lat_256", 32'(gpioIn[11]), 32'h0);
    applyStimulus(1);
    checkOutput("l255_lat_257", 32'(gpioIn[11]), 32'h1);
    padC = '0;
    applyStimulus(260);
    checkOutput("l255_fall", 32'(gpioIn), 32'h0);

    // 254-cycle glitch with L=255 never propagates.
    padC = 24'h001000;
    applyStimulus(254);
    padC = '0;
    applyStimulus(3);
    checkOutput("l255_glitch_a", 32'(gpioIn[12]), 32'h0);
    applyStimulus(260);
    checkOutput("l255_glitch_b", 32'(gpioIn[12]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
